// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity bit, one stop bit. Every bit lasts P clocks, where P is the
// prescale value captured when the request is accepted.
//
// Handshake: a request is taken on a rising CLK edge where Data_Valid=1
// and Busy=0. Busy stays high until the edge that ends the stop bit.
// Requests made while Busy=1 are dropped, never queued.
module uart_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      TX_OUT,
  output logic                      Busy,
  output logic [2:0]                dbg_state
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [PRESCALE_WIDTH-1:0] P8  = PRESCALE_WIDTH'(8);
  localparam logic [PRESCALE_WIDTH-1:0] P16 = PRESCALE_WIDTH'(16);
  localparam logic [PRESCALE_WIDTH-1:0] P32 = PRESCALE_WIDTH'(32);
  localparam logic [BIT_W-1:0]          BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                    r_state;
  logic [PRESCALE_WIDTH-1:0] r_cnt;
  logic [BIT_W-1:0]          r_bit;
  logic [DATA_WIDTH-1:0]     r_data;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic                      r_tx;
  logic                      r_busy;

  state_t                    w_state_next;
  logic [PRESCALE_WIDTH-1:0] w_cnt_next;
  logic [BIT_W-1:0]          w_bit_next;
  logic                      w_accept;
  logic                      w_tx_next;
  logic [PRESCALE_WIDTH-1:0] w_p;
  logic                      w_cnt_last;
  logic                      w_bit_last;
  logic                      w_parity;

  assign TX_OUT    = r_tx;
  assign Busy      = r_busy;
  assign dbg_state = r_state;

  // Unsupported prescale values fall back to 8 clocks per bit.
  assign w_p        = (r_prescale == P16 || r_prescale == P32) ? r_prescale : P8;
  assign w_cnt_last = (r_cnt == (w_p - PRESCALE_WIDTH'(1)));
  assign w_bit_last = (r_bit == BIT_LAST);
  assign w_parity   = (^r_data) ^ r_par_typ;

  // Next state, counters and the value TX_OUT takes after this edge.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + PRESCALE_WIDTH'(1);
    w_bit_next   = r_bit;
    w_accept     = 1'b0;
    w_tx_next    = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        w_bit_next = '0;
        if (Data_Valid && !r_busy) begin
          w_accept     = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_cnt_last) begin
          w_state_next = S_DATA;
          w_cnt_next   = '0;
          w_bit_next   = '0;
        end
      end
      S_DATA: begin
        if (w_cnt_last) begin
          w_cnt_next = '0;
          if (w_bit_last) begin
            w_bit_next   = '0;
            w_state_next = r_par_en ? S_PARITY : S_STOP;
          end else begin
            w_bit_next = r_bit + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_cnt_last) begin
          w_state_next = S_STOP;
          w_cnt_next   = '0;
        end
      end
      S_STOP: begin
        if (w_cnt_last) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
        w_bit_next   = '0;
      end
    endcase

    // The line level is registered, so it is derived from the state being entered.
    case (w_state_next)
      S_IDLE:   w_tx_next = 1'b1;
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = r_data[w_bit_next];
      S_PARITY: w_tx_next = w_parity;
      S_STOP:   w_tx_next = 1'b1;
      default:  w_tx_next = 1'b1;
    endcase
  end

  // FSM state and per-bit counters.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
    end
  end

  // Capture the request so later input changes cannot disturb the frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_prescale <= '0;
    end else if (w_accept) begin
      r_data     <= P_DATA;
      r_par_en   <= PAR_EN;
      r_par_typ  <= PAR_TYP;
      r_prescale <= prescale;
    end
  end

  // Registered line and busy flag; reset forces the line idle at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_tx   <= w_tx_next;
      r_busy <= (w_state_next != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frames are captured clock by clock and
// compared against hand-written bit sequences (bit 0 = start bit).
module tb_uart_tx;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] prescale;
  logic       TX_OUT;
  logic       Busy;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescale   (prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy),
    .dbg_state  (dbg_state)
  );

  // Clock: 10 ns period. Inputs change and outputs are sampled on negedges.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request for one clock, then scramble the inputs.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] p);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    prescale   = p;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    P_DATA     = 8'($urandom_range(0, 255));
    PAR_EN     = 1'($urandom_range(0, 1));
    PAR_TYP    = 1'($urandom_range(0, 1));
    prescale   = 6'($urandom_range(0, 63));
    check("accept_busy", 32'(Busy), 32'd1);
    check("accept_tx", 32'(TX_OUT), 32'd0);
  endtask

  // Record TX_OUT every clock while Busy is high and compare with the
  // expected bit sequence. inj >= 0 pulses Data_Valid (0xFF) at that clock.
  task automatic capture(input string tag, input logic [15:0] exp_bits,
                         input int nbits, input int p, input int inj);
    logic samp[$];
    int   cnt;
    int   bad;
    samp.delete();
    cnt = 0;
    while (Busy === 1'b1 && cnt < 1000) begin
      samp.push_back(TX_OUT);
      if (cnt == inj) begin
        P_DATA     = 8'hFF;
        Data_Valid = 1'b1;
      end
      if (inj >= 0 && cnt == inj + 1) Data_Valid = 1'b0;
      cnt++;
      @(negedge CLK);
    end
    Data_Valid = 1'b0;
    check({tag, "_len"}, 32'(cnt), 32'(nbits * p));
    for (int k = 0; k < nbits; k++) begin
      bad = 0;
      for (int j = 0; j < p; j++) begin
        if (k * p + j >= samp.size()) bad++;
        else if (samp[k * p + j] !== exp_bits[k]) bad++;
      end
      check($sformatf("%s_bit%0d_wrong_clocks", tag, k), 32'(bad), 32'd0);
    end
    check({tag, "_idle_tx"}, 32'(TX_OUT), 32'd1);
  endtask

  // Bounded wait for Busy to drop.
  task automatic wait_idle(input string tag);
    int cnt;
    cnt = 0;
    while (Busy === 1'b1 && cnt < 1000) begin
      cnt++;
      @(negedge CLK);
    end
    check({tag, "_idle_timeout"}, 32'(Busy), 32'd0);
  endtask

  int busy_seen;

  initial begin
    RST        = 1'b0;
    P_DATA     = '0;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    prescale   = 6'd8;
    repeat (3) @(negedge CLK);
    check("rst_tx", 32'(TX_OUT), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    RST = 1'b1;
    @(negedge CLK);

    // 0xA5, no parity, P=8: start 0, 1,0,1,0,0,1,0,1, stop 1.
    send(8'hA5, 1'b0, 1'b0, 6'd8);
    capture("a5", 16'b1101001010, 10, 8, -1);
    @(negedge CLK);

    // 0x03, even parity, P=16: parity 0.
    send(8'h03, 1'b1, 1'b0, 6'd16);
    capture("03even", 16'b10000000110, 11, 16, -1);
    @(negedge CLK);

    // 0x03, odd parity, P=16: parity 1.
    send(8'h03, 1'b1, 1'b1, 6'd16);
    capture("03odd", 16'b11000000110, 11, 16, -1);
    @(negedge CLK);

    // Request of 0xFF during the data bits of a 0x00 frame is dropped.
    send(8'h00, 1'b0, 1'b0, 6'd8);
    capture("ign", 16'b1000000000, 10, 8, 20);
    busy_seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (Busy === 1'b1) busy_seen++;
    end
    check("ign_no_second_frame", 32'(busy_seen), 32'd0);

    // Unsupported prescale 20 behaves as 8.
    send(8'h01, 1'b0, 1'b0, 6'd20);
    capture("p20", 16'b1000000010, 10, 8, -1);
    @(negedge CLK);

    // Data_Valid held high: next frame starts after exactly one idle clock.
    P_DATA     = 8'h81;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    prescale   = 6'd8;
    Data_Valid = 1'b1;
    @(negedge CLK);
    capture("b2b1", 16'b1100000010, 10, 8, -1);
    check("b2b_gap_busy", 32'(Busy), 32'd0);
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    check("b2b_reaccept_busy", 32'(Busy), 32'd1);
    check("b2b_reaccept_tx", 32'(TX_OUT), 32'd0);
    wait_idle("b2b2");
    @(negedge CLK);

    // Reset at clock 30 of a P=8 frame of 0x00, then send 0x5A.
    send(8'h00, 1'b0, 1'b0, 6'd8);
    repeat (29) @(negedge CLK);
    check("pre_rst_busy", 32'(Busy), 32'd1);
    check("pre_rst_tx", 32'(TX_OUT), 32'd0);
    #2 RST = 1'b0;
    #1;
    check("mid_rst_tx", 32'(TX_OUT), 32'd1);
    check("mid_rst_busy", 32'(Busy), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    send(8'h5A, 1'b0, 1'b0, 6'd8);
    capture("5a", 16'b1010110100, 10, 8, -1);

    repeat (5) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of the parallel data word.
REQ-002 Parameter: PRESCALE_WIDTH, default 6, width of the prescale input.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-004 CLK  input  1  oversampled clock; same clock and rate as the receiver's edge counter.
REQ-005 RST  input  1  asynchronous active-low reset.
REQ-006 P_DATA  input  DATA_WIDTH  parallel word to transmit.
REQ-007 Data_Valid  input  1  single-cycle request to transmit P_DATA.
REQ-008 PAR_EN  input  1  1 = append a parity bit.
REQ-009 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-010 prescale  input  PRESCALE_WIDTH  clocks per bit; legal values 8, 16, 32.
REQ-011 TX_OUT  output  1  serial line; idles high.
REQ-012 Busy  output  1  high while a frame is in progress.

Function
REQ-013 The block SHALL accept a request only when Busy=0 and Data_Valid=1 at a rising CLK edge.
REQ-014 On acceptance, the block SHALL latch P_DATA, PAR_EN, PAR_TYP and prescale into internal registers; later input changes SHALL NOT affect the frame in flight.
REQ-015 The block SHALL treat a latched prescale other than 8, 16 or 32 as 8.
REQ-016 The FSM SHALL have five states: IDLE, START, DATA, PARITY, STOP.
REQ-017 FSM transitions SHALL be: IDLE->START on acceptance; START->DATA; DATA->PARITY if PAR_EN is latched, else DATA->STOP; PARITY->STOP; STOP->IDLE.
REQ-018 Each non-IDLE state SHALL last exactly P clocks per bit, where P is the effective latched prescale.
- A clocks-per-bit counter runs from 0 to P-1.
- A bit index runs from 0 to DATA_WIDTH-1; DATA lasts DATA_WIDTH*P clocks.
REQ-019 TX_OUT SHALL be registered and driven as follows:
- IDLE: 1.
- START: 0.
- DATA: latched data bit[index], LSB first.
- PARITY: parity bit.
- STOP: 1.
REQ-020 The parity bit SHALL equal the XOR of all latched data bits when PAR_TYP=0, and its inverse when PAR_TYP=1.
REQ-021 Busy SHALL be registered, rise at the acceptance edge, and fall at the edge that returns the FSM to IDLE.
REQ-022 Latency: the acceptance edge SHALL drive TX_OUT=0 and Busy=1 in the same cycle, i.e. visible immediately after that edge.
REQ-023 Frame length SHALL be (DATA_WIDTH+2+PAR_EN)*P clocks.
REQ-024 Data_Valid asserted while Busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-025 Back-to-back frames: a new request SHALL be accepted no earlier than the first cycle after Busy falls, giving a minimum of one IDLE clock with TX_OUT=1.
REQ-026 The counters SHALL not wrap beyond P-1 or DATA_WIDTH-1, and SHALL clear on every state transition.

Reset
REQ-027 While RST=0, outputs SHALL be TX_OUT=1 and Busy=0, the FSM SHALL be in IDLE, and all counters and latched registers SHALL be 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, forcing TX_OUT=1 asynchronously.
REQ-029 After reset release, the block SHALL accept a new request on the first qualifying edge.

Verification
REQ-030 P_DATA=0xA5, PAR_EN=0, prescale=8 -> TX_OUT bits 0,1,0,1,0,0,1,0,1,1, each held 8 clocks; Busy high exactly 80 clocks.
REQ-031 P_DATA=0x03, PAR_EN=1, PAR_TYP=0, prescale=16 -> parity bit 0; frame length 176 clocks; stop bit 1.
REQ-032 Same as REQ-031 with PAR_TYP=1 -> parity bit 1; all other bits unchanged.
REQ-033 Pulse Data_Valid with P_DATA=0xFF during the DATA state of a 0x00 frame -> the 0x00 frame completes intact; no second frame is sent.
REQ-034 Assert RST at clock 30 of a prescale=8 frame -> TX_OUT=1 and Busy=0 immediately; a new request of 0x5A after release transmits correctly.
REQ-035 prescale=20 with P_DATA=0x01 -> each bit held 8 clocks; frame length 80 clocks.
